// File: rtl/alu_issuer.sv
// Bus master for the serial ALU operand protocol: takes one request, clears the ALU,
// loads operands M then Q, collects one or two result words and returns a response.
module alu_issuer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_hi,
    output logic [W-1:0] resp_lo,
    output logic [3:0]   resp_flags,
    output logic         resp_err,
    output logic         alu_rst_b,
    output logic         alu_start,
    output logic [1:0]   alu_s,
    output logic [W-1:0] alu_inbus,
    input  logic [W-1:0] alu_outbus,
    input  logic         alu_finish,
    input  logic         alu_negative,
    input  logic         alu_zero,
    input  logic         alu_carry,
    input  logic         alu_overflow
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; a response, once valid, holds every resp_* field until resp_ready is seen.
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD_M, S_LOAD_Q, S_WAIT, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           word_q, word_d;
    logic [W-1:0]   resp_hi_q, resp_hi_d;
    logic [W-1:0]   resp_lo_q, resp_lo_d;
    logic [3:0]     resp_flags_q, resp_flags_d;
    logic           resp_err_q, resp_err_d;
    logic           resp_valid_q, resp_valid_d;
    logic           req_ready_q, req_ready_d;
    logic           alu_rst_b_q, alu_rst_b_d;
    logic           alu_start_q, alu_start_d;
    logic [1:0]     alu_s_q, alu_s_d;
    logic [W-1:0]   alu_inbus_q, alu_inbus_d;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        resp_hi_d    = resp_hi_q;
        resp_lo_d    = resp_lo_q;
        resp_flags_d = resp_flags_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d         = req_op;
                    a_d          = req_a;
                    b_d          = req_b;
                    word_d       = 1'b0;
                    resp_hi_d    = '0;
                    resp_lo_d    = '0;
                    resp_flags_d = '0;
                    resp_err_d   = 1'b0;
                    state_d      = S_CLR;
                end
            end
            S_CLR:    state_d = S_LOAD_M;
            S_LOAD_M: state_d = S_LOAD_Q;
            S_LOAD_Q: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // op[1] set means mul/div, which return two words (hi first).
                if (alu_finish) begin
                    if (op_q[1] && !word_q) begin
                        resp_hi_d = alu_outbus;
                        word_d    = 1'b1;
                    end else begin
                        resp_lo_d    = alu_outbus;
                        resp_flags_d = {alu_negative, alu_zero, alu_carry, alu_overflow};
                        state_d      = S_RESP;
                    end
                end
                // A finish on the expiry cycle wins over the timeout.
                if (state_d == S_WAIT && cnt_q == CNT_LAST) begin
                    resp_err_d = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state decodes to.
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        alu_rst_b_d  = (state_d != S_CLR);
        alu_start_d  = (state_d == S_LOAD_M);
        alu_s_d      = (state_d == S_IDLE || state_d == S_CLR) ? 2'b00 : op_d;
        case (state_d)
            S_LOAD_M:                 alu_inbus_d = a_d;
            S_LOAD_Q, S_WAIT, S_RESP: alu_inbus_d = b_d;
            default:                  alu_inbus_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            word_q       <= 1'b0;
            resp_hi_q    <= '0;
            resp_lo_q    <= '0;
            resp_flags_q <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
            alu_rst_b_q  <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_s_q      <= '0;
            alu_inbus_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            resp_hi_q    <= resp_hi_d;
            resp_lo_q    <= resp_lo_d;
            resp_flags_q <= resp_flags_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            alu_rst_b_q  <= alu_rst_b_d;
            alu_start_q  <= alu_start_d;
            alu_s_q      <= alu_s_d;
            alu_inbus_q  <= alu_inbus_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_hi    = resp_hi_q;
    assign resp_lo    = resp_lo_q;
    assign resp_flags = resp_flags_q;
    assign resp_err   = resp_err_q;
    assign alu_rst_b  = alu_rst_b_q;
    assign alu_start  = alu_start_q;
    assign alu_s      = alu_s_q;
    assign alu_inbus  = alu_inbus_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer: the bench plays the ALU, checking the control sequence
// and the captured response on the falling edge of each cycle.
module tb_alu_issuer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_hi;
    logic [W-1:0] resp_lo;
    logic [3:0]   resp_flags;
    logic         resp_err;
    logic         alu_rst_b;
    logic         alu_start;
    logic [1:0]   alu_s;
    logic [W-1:0] alu_inbus;
    logic [W-1:0] alu_outbus;
    logic         alu_finish;
    logic         alu_negative, alu_zero, alu_carry, alu_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_issuer #(.W(W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_flags(resp_flags), .resp_err(resp_err),
        .alu_rst_b(alu_rst_b), .alu_start(alu_start), .alu_s(alu_s),
        .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_finish(alu_finish),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow)
    );

    // clock / cycle counter / watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp test completion");
        $fatal(1, "watchdog");
    end

    // driver tasks: present a request, return once it is accepted (at the CLR cycle)
    task automatic send_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output bit ok, output int acc_cyc);
        ok = 1'b0;
        acc_cyc = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
    endtask

    task automatic pulse_finish(input logic [W-1:0] data, input logic [3:0] fl);
        alu_finish = 1'b1; alu_outbus = data;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = fl;
        @(negedge clk);
        alu_finish = 1'b0; alu_outbus = '0;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        checks++; if (alu_rst_b !== 1'b0) begin errors++; $display("FAIL rst_alu_rst_b got %b exp 0", alu_rst_b); end
        checks++; if ({resp_valid, resp_err, alu_start, alu_s} !== 5'b0) begin errors++; $display("FAIL rst_ctrl got %b exp 00000", {resp_valid, resp_err, alu_start, alu_s}); end
        checks++; if ({resp_hi, resp_lo, resp_flags, alu_inbus} !== '0) begin errors++; $display("FAIL rst_data got %h/%h/%h/%h exp 0", resp_hi, resp_lo, resp_flags, alu_inbus); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
        checks++; if (alu_rst_b !== 1'b1) begin errors++; $display("FAIL rst_release_rst_b got %b exp 1", alu_rst_b); end
    endtask

    task automatic test_add();
        bit ok; int t0;
        send_req(2'b00, 16'h0863, 16'h0005, ok, t0);
        checks++; if (!ok) begin errors++; $display("FAIL add_accept got no ready exp ready"); end
        checks++; if ({alu_rst_b, alu_start} !== 2'b00) begin errors++; $display("FAIL add_c1 rst_b/start got %b exp 00", {alu_rst_b, alu_start}); end
        @(negedge clk);
        checks++; if ({alu_rst_b, alu_start, alu_s} !== 4'b1100 || alu_inbus !== 16'h0863) begin errors++; $display("FAIL add_c2 got %b inbus %h exp 1100 inbus 0863", {alu_rst_b, alu_start, alu_s}, alu_inbus); end
        @(negedge clk);
        checks++; if (alu_start !== 1'b0 || alu_inbus !== 16'h0005) begin errors++; $display("FAIL add_c3 got start %b inbus %h exp 0 0005", alu_start, alu_inbus); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (resp_valid !== 1'b0 || alu_inbus !== 16'h0005 || alu_start !== 1'b0) begin errors++; $display("FAIL add_wait%0d got valid %b inbus %h exp 0 0005", i, resp_valid, alu_inbus); end
            @(negedge clk);
        end
        pulse_finish(16'h0868, 4'b0000);
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL add_valid got valid %b ready %b exp 1 0", resp_valid, req_ready); end
        checks++; if (resp_lo !== 16'h0868 || resp_hi !== 16'h0000 || resp_err !== 1'b0) begin errors++; $display("FAIL add_data got %h %h err %b exp 0000 0868 0", resp_hi, resp_lo, resp_err); end
        take_resp();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL add_done got valid %b ready %b exp 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_mul();
        bit ok; int t0;
        send_req(2'b10, 16'd2147, 16'd5, ok, t0);
        checks++; if (!ok) begin errors++; $display("FAIL mul_accept got no ready exp ready"); end
        repeat (3) @(negedge clk);
        // zero flag on the first word must not be captured
        pulse_finish(16'h0000, 4'b0100);
        checks++; if (alu_s !== 2'b10 || resp_valid !== 1'b0) begin errors++; $display("FAIL mul_mid got s %b valid %b exp 10 0", alu_s, resp_valid); end
        pulse_finish(16'h29EF, 4'b0000);
        checks++; if (resp_valid !== 1'b1 || alu_s !== 2'b10) begin errors++; $display("FAIL mul_valid got valid %b s %b exp 1 10", resp_valid, alu_s); end
        checks++; if (resp_hi !== 16'h0000 || resp_lo !== 16'h29EF || resp_flags !== 4'b0000) begin errors++; $display("FAIL mul_data got %h %h fl %b exp 0000 29ef 0000", resp_hi, resp_lo, resp_flags); end
        take_resp();
        checks++; if (alu_s !== 2'b00) begin errors++; $display("FAIL mul_idle_s got %b exp 00", alu_s); end
    endtask

    task automatic test_div();
        bit ok; int t0; int early;
        early = 0;
        send_req(2'b11, 16'd2147, 16'd5, ok, t0);
        checks++; if (!ok) begin errors++; $display("FAIL div_accept got no ready exp ready"); end
        repeat (3) @(negedge clk);
        pulse_finish(16'h0002, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            if (resp_valid !== 1'b0 || alu_s !== 2'b11) early++;
            @(negedge clk);
        end
        checks++; if (early != 0) begin errors++; $display("FAIL div_gap got %0d bad cycles exp 0", early); end
        pulse_finish(16'h01AD, 4'b0010);
        checks++; if (resp_valid !== 1'b1 || resp_hi !== 16'h0002 || resp_lo !== 16'h01AD || resp_flags !== 4'b0010) begin errors++; $display("FAIL div_data got v %b %h %h fl %b exp 1 0002 01ad 0010", resp_valid, resp_hi, resp_lo, resp_flags); end
        take_resp();
    endtask

    task automatic test_flags_backpressure();
        bit ok; int t0; int bad;
        bad = 0;
        send_req(2'b01, 16'h7FFF, 16'hFFFF, ok, t0);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept got no ready exp ready"); end
        repeat (3) @(negedge clk);
        pulse_finish(16'h8000, 4'b1001);
        for (int i = 0; i < 7; i++) begin
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_lo !== 16'h8000 || resp_hi !== 16'h0000 || resp_flags !== 4'b1001 || resp_err !== 1'b0) bad++;
            // stray finish outside WAIT must be ignored
            if (i == 2) pulse_finish(16'hBEEF, 4'b0110);
            else @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles exp 0", bad); end
        checks++; if (resp_flags !== 4'b1001 || resp_lo !== 16'h8000) begin errors++; $display("FAIL bp_flags got %b %h exp 1001 8000", resp_flags, resp_lo); end
        take_resp();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_done got valid %b ready %b exp 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1; int t0, t1;
        send_req(2'b00, 16'd1, 16'd2, ok0, t0);
        repeat (3) @(negedge clk);
        pulse_finish(16'h0003, 4'b0000);
        checks++; if (resp_valid !== 1'b1 || resp_lo !== 16'h0003 || cyc - t0 != 5) begin errors++; $display("FAIL b2b_latency got valid %b lo %h lat %0d exp 1 0003 5", resp_valid, resp_lo, cyc - t0); end
        resp_ready = 1'b1;
        send_req(2'b01, 16'd9, 16'd4, ok1, t1);
        resp_ready = 1'b0;
        checks++; if (!ok0 || !ok1 || t1 - t0 != 6) begin errors++; $display("FAIL b2b_gap got %0d exp 6", t1 - t0); end
        repeat (3) @(negedge clk);
        pulse_finish(16'h0005, 4'b0000);
        checks++; if (resp_valid !== 1'b1 || resp_lo !== 16'h0005) begin errors++; $display("FAIL b2b_second got valid %b lo %h exp 1 0005", resp_valid, resp_lo); end
        take_resp();
    endtask

    task automatic test_timeout();
        bit ok; int t0; int early;
        early = 0;
        send_req(2'b10, 16'd2147, 16'd5, ok, t0);
        repeat (3) @(negedge clk);
        pulse_finish(16'h1234, 4'b1111);
        for (int i = 1; i < 64; i++) begin
            if (resp_valid !== 1'b0) early++;
            @(negedge clk);
        end
        checks++; if (!ok || early != 0) begin errors++; $display("FAIL to_early got %0d early exp 0", early); end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL to_valid got valid %b err %b exp 1 1", resp_valid, resp_err); end
        checks++; if (resp_hi !== 16'h1234 || resp_lo !== 16'h0000 || resp_flags !== 4'b0000) begin errors++; $display("FAIL to_data got %h %h fl %b exp 1234 0000 0000", resp_hi, resp_lo, resp_flags); end
        take_resp();
    endtask

    task automatic test_timeout_edge();
        bit ok; int t0;
        send_req(2'b00, 16'd4, 16'd4, ok, t0);
        repeat (3) @(negedge clk);
        repeat (63) @(negedge clk);
        pulse_finish(16'h0008, 4'b0000);
        checks++; if (!ok || resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_lo !== 16'h0008) begin errors++; $display("FAIL to_edge got valid %b err %b lo %h exp 1 0 0008", resp_valid, resp_err, resp_lo); end
        take_resp();
    endtask

    task automatic test_reset_mid_op();
        bit ok; int t0; int seen;
        seen = 0;
        send_req(2'b00, 16'h1111, 16'h2222, ok, t0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (alu_rst_b !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL mid_in_rst got rst_b %b ready %b valid %b exp 0 0 0", alu_rst_b, req_ready, resp_valid); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || alu_rst_b !== 1'b1 || alu_start !== 1'b0 || alu_s !== 2'b00 || alu_inbus !== 16'h0000) begin errors++; $display("FAIL mid_after got ready %b rst_b %b start %b s %b inbus %h exp 1 1 0 00 0000", req_ready, alu_rst_b, alu_start, alu_s, alu_inbus); end
        pulse_finish(16'h3333, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 1'b0 || resp_lo !== 16'h0000) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_resp got %0d bad cycles exp 0", seen); end
        send_req(2'b00, 16'h0010, 16'h0020, ok, t0);
        repeat (3) @(negedge clk);
        pulse_finish(16'h0030, 4'b0000);
        checks++; if (!ok || resp_valid !== 1'b1 || resp_lo !== 16'h0030 || resp_err !== 1'b0) begin errors++; $display("FAIL mid_new_add got valid %b lo %h err %b exp 1 0030 0", resp_valid, resp_lo, resp_err); end
        take_resp();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
        resp_ready = 1'b0; alu_outbus = '0; alu_finish = 1'b0;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
        @(negedge clk);
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_flags_backpressure();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issuer.md
# alu_issuer

Bus master for the serial ALU operand protocol. It accepts one operation request (opcode plus two 16-bit operands) over a valid/ready handshake and clears the ALU. It then drives `start`, `s` and `inbus` to load operand M followed by operand Q, and waits for one or two `finish` pulses. It captures the result word(s) and status flags and returns them over a valid/ready response channel. It sits between the processor control unit and the ALU and owns every ALU-side control signal.

## Interface
- `W`, 16: data width of operands, `inbus` and `outbus`.
- `TIMEOUT`, 64: maximum WAIT cycles before the operation is aborted with an error.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  issuer can accept a request.
- `req_op`  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- `req_a`  in  W  operand M.
- `req_b`  in  W  operand Q.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_hi`  out  W  mul: high word; div: remainder; add/sub: 0.
- `resp_lo`  out  W  mul: low word; div: quotient; add/sub: result.
- `resp_flags`  out  4  {negative, zero, carry, overflow}, captured on the final finish pulse.
- `resp_err`  out  1  the operation timed out.
- `alu_rst_b`  out  1  ALU reset, active-low.
- `alu_start`  out  1  ALU start.
- `alu_s`  out  2  ALU operation select.
- `alu_inbus`  out  W  ALU operand bus.
- `alu_outbus`  in  W  ALU result bus.
- `alu_finish`  in  1  one-cycle pulse per result word.
- `alu_negative`, `alu_zero`, `alu_carry`, `alu_overflow`  in  1 each  ALU flags.

## Operation
- **States:** IDLE, CLR, LOAD_M, LOAD_Q, WAIT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, latch op, a and b, then go to CLR.
- **CLR:** `alu_rst_b`=0 for exactly one cycle, then LOAD_M.
- **LOAD_M:** `alu_start`=1, `alu_s`=op, `alu_inbus`=a, then LOAD_Q.
- **LOAD_Q:** `alu_start`=0, `alu_inbus`=b, then WAIT.
  - `alu_s` holds op from LOAD_M until the return to IDLE.
- **WAIT:**
  - `alu_inbus` holds b.
  - The cycle counter starts at 0 and increments every WAIT cycle.
  - Words expected: 1 for add/sub, 2 for mul/div.
  - For add/sub, the single finish pulse captures `alu_outbus` into `resp_lo`, and `resp_hi` is set to 0.
  - For mul/div, the first finish pulse captures into `resp_hi` and the second into `resp_lo`.
  - The flags are captured on the final expected pulse.
  - After the final pulse, go to RESP with err=0.
  - If the counter reaches `TIMEOUT`-1 without the final pulse, go to RESP with err=1.
    - Words already captured are kept; uncaptured words are 0; flags are 0.
- **RESP:**
  - `resp_valid`=1 and all `resp_*` are held stable.
  - On `resp_ready`, go to IDLE.
- `alu_finish` outside WAIT is ignored.
- Finish pulses in excess of the expected count cannot occur, because the state leaves WAIT on the final pulse.
- A finish pulse in the same cycle as timeout expiry counts as success: the finish takes priority.
- **Reset:**
  - State goes to IDLE, counters and captured data are cleared.
  - `alu_rst_b`=0 while `rst`=1.
  - Reset mid-operation aborts the operation and produces no response.

## Timing
- **Reset values:**
  - `req_ready`=0 during reset, 1 in the first cycle after reset.
  - `resp_valid`=0, `resp_hi`=0, `resp_lo`=0, `resp_flags`=0, `resp_err`=0.
  - `alu_start`=0, `alu_s`=0, `alu_inbus`=0, `alu_rst_b`=0.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- **Per-operation cycle sequence** (accept edge = cycle 0):
  - Cycle 1: CLR.
  - Cycle 2: LOAD_M, with `alu_start` high.
  - Cycle 3: LOAD_Q.
  - Cycles 4 onward: WAIT.
- **Response latency:**
  - `resp_valid` rises on the cycle after the final finish pulse is sampled.
  - Minimum accept-to-`resp_valid` latency is 5 cycles, reached when finish arrives in the first WAIT cycle.
- **Throughput:**
  - `req_ready` is low from the accept edge until the cycle after the `resp_ready` handshake.
  - There is no accept in the same cycle as the response handshake; the minimum gap between accepts is 6 cycles.

## Test plan
- **Add:**
  - Stimulus: op=00, a=0x0863 (2147), b=0x0005; the ALU model pulses finish 3 WAIT cycles after entering WAIT with outbus=0x0868.
  - Required response: `alu_rst_b` low in cycle 1, start high only in cycle 2 with inbus=0x0863, inbus=0x0005 in cycle 3; resp_lo=0x0868, resp_hi=0, err=0.
- **Mul:**
  - Stimulus: op=10, a=2147, b=5; the model gives two consecutive finish pulses, 0x0000 then 0x29EF.
  - Required response: resp_hi=0x0000, resp_lo=0x29EF, `alu_s`=10 held through WAIT.
- **Div:**
  - Stimulus: op=11, a=2147, b=5; the model gives pulses 0x0002 then 0x01AD, with a 10-cycle gap between them.
  - Required response: resp_hi=0x0002, resp_lo=0x01AD.
- **Flags and backpressure:**
  - Stimulus: sub with the model returning outbus=0x8000 and flags negative=1, overflow=1; hold `resp_ready`=0 for 7 cycles.
  - Required response: resp_flags=4'b1001, outputs stable for all 7 cycles, `req_ready` stays 0 until the handshake completes.
- **Timeout:**
  - Stimulus: mul where the model gives one finish pulse (0x1234), then silence, with TIMEOUT=64.
  - Required response: resp_valid exactly 64 WAIT cycles after WAIT entry, err=1, resp_hi=0x1234, resp_lo=0.
- **Reset mid-operation:**
  - Stimulus: assert `rst` during WAIT, release it, then issue an add.
  - Required response: no response for the aborted operation, all outputs at reset values, and the new add completes normally.
